// File: rtl/systolic_mac_array.sv
// systolic_mac_array: N x N output-stationary array of unsigned MAC PEs.
// Row operands flow left-to-right, column operands top-to-bottom, one register
// per hop. Each PE accumulates the products of matching valid operand pairs.
// Once PE(N-1,N-1) completes its K-th MAC the whole array freezes and the
// accumulators are presented on res_flat until rst or clear.
module systolic_mac_array #(
    parameter int D_W   = 8,
    parameter int N     = 2,
    parameter int K     = 2,
    parameter int ACC_W = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [N*D_W-1:0]     in_x_flat,
    input  logic [N-1:0]         in_x_vld,
    input  logic [N*D_W-1:0]     in_y_flat,
    input  logic [N-1:0]         in_y_vld,
    output logic                 busy,
    output logic                 done,
    output logic                 res_valid,
    output logic [N*N*ACC_W-1:0] res_flat,
    output logic                 err
);
    localparam int CNT_W = $clog2(K + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_RESULT} state_t;
    state_t state_q, state_d;

    logic [N-1:0][N-1:0][D_W-1:0]   a_q, a_d, b_q, b_d, a_in, b_in;
    logic [N-1:0][N-1:0]            av_q, av_d, bv_q, bv_d, av_in, bv_in, mac;
    logic [N-1:0][N-1:0][2*D_W-1:0] prod;
    logic [N-1:0][N-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [N-1:0][N-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                           err_q, err_d, done_q, done_d;
    logic                           frozen, start, last_mac;

    assign frozen   = (state_q == S_RESULT);
    assign start    = in_x_vld[0] & in_y_vld[0];
    // The last PE completing its K-th MAC ends the computation.
    assign last_mac = mac[N-1][N-1] && (cnt_q[N-1][N-1] == CNT_LAST);

    // Operand routing: edge PEs take the input lanes, inner PEs their neighbour's registers.
    always_comb begin
        a_in  = '0;
        av_in = '0;
        b_in  = '0;
        bv_in = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) begin
                    a_in[i][j]  = in_x_flat[i*D_W +: D_W];
                    av_in[i][j] = in_x_vld[i];
                end else begin
                    a_in[i][j]  = a_q[i][(j > 0) ? j - 1 : 0];
                    av_in[i][j] = av_q[i][(j > 0) ? j - 1 : 0];
                end
                if (i == 0) begin
                    b_in[i][j]  = in_y_flat[j*D_W +: D_W];
                    bv_in[i][j] = in_y_vld[j];
                end else begin
                    b_in[i][j]  = b_q[(i > 0) ? i - 1 : 0][j];
                    bv_in[i][j] = bv_q[(i > 0) ? i - 1 : 0][j];
                end
            end
        end
    end

    // PE datapath: shift operands one hop, MAC on matched valids, flag lone valids.
    always_comb begin
        a_d   = a_q;
        av_d  = av_q;
        b_d   = b_q;
        bv_d  = bv_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        mac   = '0;
        prod  = '0;
        if (!frozen) begin
            a_d  = a_in;
            av_d = av_in;
            b_d  = b_in;
            bv_d = bv_in;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    prod[i][j] = {{D_W{1'b0}}, a_in[i][j]} * {{D_W{1'b0}}, b_in[i][j]};
                    mac[i][j]  = av_in[i][j] & bv_in[i][j];
                    if (mac[i][j]) begin
                        acc_d[i][j] = acc_q[i][j] + ACC_W'(prod[i][j]);
                        cnt_d[i][j] = cnt_q[i][j] + CNT_W'(1);
                    end else if (av_in[i][j] ^ bv_in[i][j]) begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state logic; done fires on the single edge that enters RESULT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = last_mac ? S_RESULT : S_COMPUTE;
            S_COMPUTE: if (last_mac) state_d = S_RESULT;
            S_RESULT:  state_d = S_RESULT;
            default:   state_d = S_IDLE;
        endcase
        done_d = (state_q != S_RESULT) && (state_d == S_RESULT);
    end

    // State and pipeline registers; clear behaves exactly like rst.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            av_q    <= '0;
            b_q     <= '0;
            bv_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            av_q    <= av_d;
            b_q     <= b_d;
            bv_q    <= bv_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Outputs decoded from state; accumulators flattened row-major.
    always_comb begin
        busy      = (state_q == S_COMPUTE);
        res_valid = (state_q == S_RESULT);
        done      = done_q;
        err       = err_q;
        res_flat  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                res_flat[(i*N+j)*ACC_W +: ACC_W] = acc_q[i][j];
            end
        end
    end
endmodule
